// File: rtl/alien_fire_ctrl.sv
// Alien fire controller: paces alien shots with a frame-count cooldown,
// picks a starting column with a Galois LFSR, scans bottom-up for the lowest
// live alien and holds a level fire request (with muzzle coordinates) until
// the bullet stage reports a bullet in flight.
module alien_fire_ctrl #(
  parameter int          COLS            = 8,
  parameter int          ROWS            = 4,
  parameter int          ALIEN_W         = 32,
  parameter int          ALIEN_H         = 24,
  parameter int          SPACING_X       = 48,
  parameter int          SPACING_Y       = 40,
  parameter int          COOLDOWN_FRAMES = 60,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic                 pixel_clk,
  input  logic                 rst,
  input  logic                 fsync,
  input  logic [ROWS*COLS-1:0] alive,
  input  logic [11:0]          group_x,
  input  logic [11:0]          group_y,
  input  logic                 bullet_active,
  output logic                 fire,
  output logic [11:0]          alien_x,
  output logic [11:0]          alien_y,
  output logic [7:0]           shot_count
);

  localparam int CW = $clog2(COLS);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int TW = CW + 1;
  localparam int FW = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES) : 1;
  localparam int IW = $clog2(ROWS * COLS);

  // Galois feedback mask for taps 16,14,13,11 (right-shifting form).
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    S_COOLDOWN,
    S_PICK,
    S_SCAN,
    S_ARMED
  } state_t;

  state_t          state_q, state_d;
  logic [FW-1:0]   frame_q, frame_d;
  logic [15:0]     lfsr_q,  lfsr_d;
  logic [CW-1:0]   col_q,   col_d;
  logic [RW-1:0]   row_q,   row_d;
  logic [TW-1:0]   tries_q, tries_d;
  logic [11:0]     x_q,     x_d;
  logic [11:0]     y_q,     y_d;
  logic [7:0]      shot_q,  shot_d;

  logic [15:0]     lfsr_step;
  logic [IW-1:0]   cell_idx;
  logic [11:0]     hit_x;
  logic [11:0]     hit_y;

  // Next-state, LFSR stepping and muzzle coordinate computation.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d  = state_q;
    frame_d  = frame_q;
    col_d    = col_q;
    row_d    = row_q;
    tries_d  = tries_q;
    x_d      = x_q;
    y_d      = y_q;
    shot_d   = shot_q;

    lfsr_step = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
    lfsr_d    = fsync ? lfsr_step : lfsr_q;

    // COLS is a power of two, so {row, col} equals row*COLS + col.
    cell_idx = IW'({row_q, col_q});
    hit_x    = group_x + 12'(col_q) * 12'(SPACING_X) + 12'(ALIEN_W / 2);
    hit_y    = group_y + 12'(row_q) * 12'(SPACING_Y) + 12'(ALIEN_H);

    unique case (state_q)
      S_COOLDOWN: begin
        if (fsync) begin
          if (frame_q == FW'(COOLDOWN_FRAMES - 1)) begin
            // Saturated; release only once the previous bullet is gone.
            if (!bullet_active) state_d = S_PICK;
          end else begin
            frame_d = frame_q + FW'(1);
          end
        end
      end

      S_PICK: begin
        col_d   = lfsr_q[CW-1:0];
        row_d   = RW'(ROWS - 1);
        tries_d = '0;
        state_d = S_SCAN;
      end

      S_SCAN: begin
        if (alive[cell_idx]) begin
          x_d     = hit_x;
          y_d     = hit_y;
          state_d = S_ARMED;
        end else if (row_q != '0) begin
          row_d = row_q - RW'(1);
        end else begin
          col_d   = col_q + CW'(1);
          row_d   = RW'(ROWS - 1);
          tries_d = tries_q + TW'(1);
          // Every column visited without a hit: the formation is empty.
          if (tries_q == TW'(COLS - 1)) begin
            state_d = S_COOLDOWN;
            frame_d = '0;
          end
        end
      end

      S_ARMED: begin
        if (bullet_active) begin
          shot_d  = shot_q + 8'd1;
          frame_d = '0;
          state_d = S_COOLDOWN;
        end
      end

      default: state_d = S_COOLDOWN;
    endcase
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge pixel_clk) begin
    // NOTE: non-blocking assignments so every register updates from the same
    // pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= S_COOLDOWN;
      frame_q <= '0;
      lfsr_q  <= LFSR_SEED;
      col_q   <= '0;
      row_q   <= '0;
      tries_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      shot_q  <= '0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      lfsr_q  <= lfsr_d;
      col_q   <= col_d;
      row_q   <= row_d;
      tries_q <= tries_d;
      x_q     <= x_d;
      y_q     <= y_d;
      shot_q  <= shot_d;
    end
  end

  assign fire       = (state_q == S_ARMED);
  assign alien_x    = x_q;
  assign alien_y    = y_q;
  assign shot_count = shot_q;

endmodule

// File: tb/tb_alien_fire_ctrl.sv
// Directed testbench for alien_fire_ctrl with hand-computed expectations.
// COOLDOWN_FRAMES=4, formation at (100,50). With the default seed 16'hACE1 the
// LFSR after four steps is 16'h1C4E, so the first pick is column 6 and an
// all-alive formation fires from (116+48*6, 50+3*40+24) = (404, 194).
module tb_alien_fire_ctrl;

  localparam int COLS = 8;
  localparam int ROWS = 4;

  logic                 pixel_clk = 1'b0;
  logic                 rst;
  logic                 fsync;
  logic [ROWS*COLS-1:0] alive;
  logic [11:0]          group_x;
  logic [11:0]          group_y;
  logic                 bullet_active;
  logic                 fire;
  logic [11:0]          alien_x;
  logic [11:0]          alien_y;
  logic [7:0]           shot_count;

  int n_cmp = 0;
  int n_mis = 0;

  alien_fire_ctrl #(
    .COLS            (COLS),
    .ROWS            (ROWS),
    .COOLDOWN_FRAMES (4)
  ) dut (
    .pixel_clk     (pixel_clk),
    .rst           (rst),
    .fsync         (fsync),
    .alive         (alive),
    .group_x       (group_x),
    .group_y       (group_y),
    .bullet_active (bullet_active),
    .fire          (fire),
    .alien_x       (alien_x),
    .alien_y       (alien_y),
    .shot_count    (shot_count)
  );

  always #5 pixel_clk = ~pixel_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic pulse_fsync();
    fsync = 1'b1;
    step();
    fsync = 1'b0;
  endtask

  // Idle n cycles, counting cycles on which fire was seen high.
  task automatic run_idle(input int n, output int seen);
    seen = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (fire !== 1'b0) seen++;
    end
  endtask

  // Pulse n fsyncs with short gaps, counting any fire seen along the way.
  task automatic frames(input int n, output int seen);
    int s;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      pulse_fsync();
      if (fire !== 1'b0) seen++;
      run_idle(5, s);
      seen += s;
    end
  endtask

  // Wait up to max_cyc cycles for fire; cyc = cycles waited, or -1 on timeout.
  task automatic wait_fire(input int max_cyc, output int cyc);
    cyc = 0;
    while (fire !== 1'b1 && cyc < max_cyc) begin
      step();
      cyc++;
    end
    if (fire !== 1'b1) cyc = -1;
  endtask

  task automatic consume(input string tag, input logic [7:0] exp_shots);
    bullet_active = 1'b1;
    step();
    check({tag, "_fire_drop"}, 32'(fire), 32'd0);
    check({tag, "_shots"}, 32'(shot_count), 32'(exp_shots));
    bullet_active = 1'b0;
  endtask

  initial begin
    int cyc;
    int seen;
    int changes;

    rst           = 1'b1;
    fsync         = 1'b0;
    alive         = '1;
    group_x       = 12'd100;
    group_y       = 12'd50;
    bullet_active = 1'b0;
    step();
    step();

    check("rst_fire",  32'(fire),       32'd0);
    check("rst_x",     32'(alien_x),    32'd0);
    check("rst_y",     32'(alien_y),    32'd0);
    check("rst_shots", 32'(shot_count), 32'd0);
    rst = 1'b0;

    // T1: all alive, four fsyncs, fire two cycles after the fourth.
    frames(3, seen);
    check("t1_no_early_fire", 32'(seen), 32'd0);
    pulse_fsync();
    wait_fire(3, cyc);
    check("t1_latency", 32'(cyc),     32'd2);
    check("t1_x",       32'(alien_x), 32'd404);
    check("t1_y",       32'(alien_y), 32'd194);

    // T4: armed for 50 frames while the formation moves and aliens die.
    changes = 0;
    for (int f = 0; f < 50; f++) begin
      group_x = group_x + 12'd7;
      group_y = group_y + 12'd1;
      alive   = alive ^ (32'h1 << (f % 32));
      pulse_fsync();
      for (int k = 0; k < 4; k++) begin
        if (fire !== 1'b1 || alien_x !== 12'd404 || alien_y !== 12'd194) changes++;
        step();
      end
    end
    check("t4_hold_changes", 32'(changes), 32'd0);
    check("t4_fire_held",    32'(fire),    32'd1);
    group_x = 12'd100;
    group_y = 12'd50;
    consume("t4", 8'd1);

    // T2: only row 1, col 5 alive -> (100+240+16, 50+40+24) = (356, 114).
    alive = 32'h1 << (1 * 8 + 5);
    frames(3, seen);
    check("t2_no_early_fire", 32'(seen), 32'd0);
    pulse_fsync();
    wait_fire(ROWS * COLS + 1, cyc);
    check("t2_in_budget", 32'(cyc >= 2 && cyc <= ROWS * COLS + 1), 32'd1);
    check("t2_x", 32'(alien_x), 32'd356);
    check("t2_y", 32'(alien_y), 32'd114);
    consume("t2", 8'd2);

    // T5: bullet in flight through cooldown expiry blocks the shot.
    alive         = '1;
    bullet_active = 1'b1;
    frames(6, seen);
    check("t5_blocked_fire", 32'(seen), 32'd0);
    bullet_active = 1'b0;
    run_idle(10, seen);
    check("t5_no_fire_before_fsync", 32'(seen), 32'd0);
    pulse_fsync();
    wait_fire(3, cyc);
    check("t5_latency", 32'(cyc), 32'd2);
    consume("t5", 8'd3);

    // T6: reset while armed clears outputs and restarts cooldown and LFSR.
    frames(3, seen);
    pulse_fsync();
    wait_fire(ROWS * COLS + 1, cyc);
    check("t6_armed", 32'(fire), 32'd1);
    rst = 1'b1;
    step();
    check("t6_rst_fire",  32'(fire),       32'd0);
    check("t6_rst_x",     32'(alien_x),    32'd0);
    check("t6_rst_y",     32'(alien_y),    32'd0);
    check("t6_rst_shots", 32'(shot_count), 32'd0);
    rst = 1'b0;
    frames(3, seen);
    check("t6_no_early_fire", 32'(seen), 32'd0);
    pulse_fsync();
    wait_fire(3, cyc);
    check("t6_latency", 32'(cyc),     32'd2);
    check("t6_x",       32'(alien_x), 32'd404);
    check("t6_y",       32'(alien_y), 32'd194);

    // T3: empty formation never fires; every fourth frame rescans then
    // restarts cooldown from zero.
    rst = 1'b1;
    step();
    rst   = 1'b0;
    alive = '0;
    changes = 0;
    for (int f = 0; f < 20; f++) begin
      pulse_fsync();
      if (fire !== 1'b0) changes++;
      run_idle(40, seen);
      changes += seen;
    end
    check("t3_no_fire", 32'(changes),    32'd0);
    check("t3_shots",   32'(shot_count), 32'd0);
    alive = '1;
    frames(3, seen);
    check("t3_cooldown_restarted", 32'(seen), 32'd0);
    pulse_fsync();
    wait_fire(3, cyc);
    check("t3_refire_latency", 32'(cyc), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  // Watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
